control_sequencer: RTL and testbench

//  Hardwired control unit driving the datapath's strobes (PCout, MARin, Zin, Read, MDRin, ...).

---
 rtl/control_sequencer_if.sv | 44 ++++
 rtl/control_sequencer.sv | 91 +++++++++
 tb/tb_control_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: command inputs, IR feedback and datapath strobes of the control sequencer
interface control_sequencer_if #(
  parameter int IR_W  = 32,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Stop;
  logic             Mem_ready;
  logic [IR_W-1:0]  IR;
  logic             PCout;
  logic             Zlowout;
  logic             MDRout;
  logic             MARin;
  logic             Zin;
  logic             PCin;
  logic             MDRin;
  logic             IRin;
  logic             Yin;
  logic             IncPC;
  logic             Read;
  logic             Gra;
  logic             Grb;
  logic             Grc;
  logic             Rin;
  logic             Rout;
  logic [3:0]       ALU_op;
  logic             Run;
  logic             Illegal_op;
  logic [CNT_W-1:0] Instr_count;

  // Side that commands the sequencer and supplies IR (bench / datapath)
  modport master (
    output Start, Stop, Mem_ready, IR,
    input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
           Gra, Grb, Grc, Rin, Rout, ALU_op, Run, Illegal_op, Instr_count
  );

  // The sequencer itself
  modport slave (
    input  Start, Stop, Mem_ready, IR,
    output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
           Gra, Grb, Grc, Rin, Rout, ALU_op, Run, Illegal_op, Instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch / ALU-execute / NOP / HALT control FSM for the datapath
module control_sequencer #(
  parameter int IR_W  = 32,
  parameter int OPC_W = 5,
  parameter int CNT_W = 16
) (
  input logic               Clock,
  input logic               Clear_n,
  control_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED} state_t;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11010);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [OPC_W-1:0] w_opc;
  logic             w_alu;
  logic             w_nop;
  logic             w_halt;
  logic             w_retire;
  logic [3:0]       w_alu_code;

  assign w_opc      = bus.IR[IR_W-1 -: OPC_W];
  assign w_alu      = (w_opc == OP_ADD) || (w_opc == OP_SUB) || (w_opc == OP_AND) || (w_opc == OP_OR);
  assign w_nop      = w_opc == OP_NOP;
  assign w_halt     = w_opc == OP_HALT;
  assign w_retire   = (r_state == S_T5) || ((r_state == S_T3) && (w_nop || w_halt));
  assign w_alu_code = (w_opc == OP_ADD) ? 4'b0001 :
                      (w_opc == OP_SUB) ? 4'b0010 :
                      (w_opc == OP_AND) ? 4'b0011 :
                      (w_opc == OP_OR)  ? 4'b0100 : 4'b0000;
  assign bus.Instr_count = r_count;

  // State register
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Retired-instruction counter, wraps naturally at all-ones
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n)      r_count <= '0;
    else if (w_retire) r_count <= r_count + CNT_W'(1);
  end

  // Next-state decode; Stop is only honoured at instruction boundaries
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = bus.Start ? S_T0 : S_IDLE;
      S_T0:     w_next = S_T1;
      S_T1:     w_next = bus.Mem_ready ? S_T2 : S_T1;
      S_T2:     w_next = S_T3;
      S_T3:     w_next = w_alu ? S_T4 : (w_nop && !bus.Stop) ? S_T0 : S_HALTED;
      S_T4:     w_next = S_T5;
      S_T5:     w_next = bus.Stop ? S_HALTED : S_T0;
      S_HALTED: w_next = bus.Start ? S_T0 : S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore strobe decode from state, qualified by opcode in T3/T4
  always_comb begin
    bus.PCout      = r_state == S_T0;
    bus.MARin      = r_state == S_T0;
    bus.IncPC      = r_state == S_T0;
    bus.Zin        = (r_state == S_T0) || (r_state == S_T4);
    bus.Zlowout    = (r_state == S_T1) || (r_state == S_T5);
    bus.PCin       = r_state == S_T1;
    bus.Read       = r_state == S_T1;
    bus.MDRin      = r_state == S_T1;
    bus.MDRout     = r_state == S_T2;
    bus.IRin       = r_state == S_T2;
    bus.Grb        = (r_state == S_T3) && w_alu;
    bus.Yin        = (r_state == S_T3) && w_alu;
    bus.Rout       = ((r_state == S_T3) && w_alu) || (r_state == S_T4);
    bus.Grc        = r_state == S_T4;
    bus.ALU_op     = (r_state == S_T4) ? w_alu_code : 4'b0000;
    bus.Gra        = r_state == S_T5;
    bus.Rin        = r_state == S_T5;
    bus.Run        = (r_state != S_IDLE) && (r_state != S_HALTED);
    bus.Illegal_op = (r_state == S_T3) && !w_alu && !w_nop && !w_halt;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: vector table, directed corner cases and random run against a step-level model
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if bus ();
  control_sequencer dut (.Clock(clk), .Clear_n(rst_n), .bus(bus));

  localparam logic [21:0] PCO = 22'd1 << 21, ZLO = 22'd1 << 20, MDRO = 22'd1 << 19, MARI = 22'd1 << 18,
                          ZIN = 22'd1 << 17, PCI = 22'd1 << 16, MDRI = 22'd1 << 15, IRI = 22'd1 << 14,
                          YIN = 22'd1 << 13, INC = 22'd1 << 12, RD = 22'd1 << 11, GRA = 22'd1 << 10,
                          GRB = 22'd1 << 9, GRC = 22'd1 << 8, RIN = 22'd1 << 7, ROUT = 22'd1 << 6,
                          RUN = 22'd1 << 1, ILL = 22'd1;
  localparam logic [21:0] E_T0  = PCO | MARI | INC | ZIN | RUN;
  localparam logic [21:0] E_T1  = ZLO | PCI | RD | MDRI | RUN;
  localparam logic [21:0] E_T2  = MDRO | IRI | RUN;
  localparam logic [21:0] E_T3A = GRB | ROUT | YIN | RUN;
  localparam logic [21:0] E_T4  = GRC | ROUT | ZIN | RUN;
  localparam logic [21:0] E_T5  = ZLO | GRA | RIN | RUN;
  localparam logic [31:0] I_AND = 32'h2891_8000, I_NOP = 32'hD000_0000, I_HALT = 32'hD800_0000;
  localparam logic [31:0] I_ILL = 32'hF800_0000, I_ADD = 32'h1800_0000, I_SUB = 32'h2000_0000;

  logic [21:0] act;
  assign act = {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin,
                bus.Yin, bus.IncPC, bus.Read, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                bus.ALU_op, bus.Run, bus.Illegal_op};

  typedef struct {
    logic        st;
    logic        sp;
    logic        mr;
    logic [31:0] ir;
    logic [21:0] ev;
    int          ec;
  } vec_t;
  vec_t tv[16];

  int total = 0;
  int bad = 0;
  int m_step = -1;
  int m_cnt = 0;

  function automatic logic [21:0] alu_f(int code);
    return 22'(code) << 2;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic st, logic sp, logic mr, logic [31:0] ir);
    bus.Start = st;
    bus.Stop = sp;
    bus.Mem_ready = mr;
    bus.IR = ir;
  endtask

  // Expected strobes for an instruction step (-1 = not running) and opcode
  function automatic logic [21:0] model_out(int s, logic [4:0] o);
    logic alu;
    alu = o >= 5'd3 && o <= 5'd6;
    case (s)
      0: return E_T0;
      1: return E_T1;
      2: return E_T2;
      3: return alu ? E_T3A : (o == 5'd26 || o == 5'd27) ? RUN : (RUN | ILL);
      4: return E_T4 | (alu ? alu_f(int'(o) - 2) : 22'd0);
      5: return E_T5;
      default: return 22'd0;
    endcase
  endfunction

  // Advance the instruction-step model by one clock using the inputs present at the edge
  task automatic model_step();
    logic [4:0] o;
    o = bus.IR[31:27];
    case (m_step)
      -1: m_step = bus.Start ? 0 : -1;
      0: m_step = 1;
      1: m_step = bus.Mem_ready ? 2 : 1;
      2: m_step = 3;
      3: begin
        if (o >= 5'd3 && o <= 5'd6) m_step = 4;
        else begin
          if (o == 5'd26 || o == 5'd27) m_cnt = (m_cnt + 1) % 65536;
          m_step = (o == 5'd26 && !bus.Stop) ? 0 : -1;
        end
      end
      4: m_step = 5;
      default: begin
        m_cnt = (m_cnt + 1) % 65536;
        m_step = bus.Stop ? -1 : 0;
      end
    endcase
  endtask

  initial begin
    drive(0, 0, 1, '0);
    tv[0]  = '{1, 0, 1, I_AND,  E_T0, 0};
    tv[1]  = '{0, 0, 1, I_AND,  E_T1, 0};
    tv[2]  = '{0, 0, 1, I_AND,  E_T2, 0};
    tv[3]  = '{0, 0, 1, I_AND,  E_T3A, 0};
    tv[4]  = '{0, 0, 1, I_AND,  E_T4 | alu_f(3), 0};
    tv[5]  = '{0, 0, 1, I_AND,  E_T5, 0};
    tv[6]  = '{0, 0, 1, I_AND,  E_T0, 1};
    tv[7]  = '{0, 0, 1, I_NOP,  E_T1, 1};
    tv[8]  = '{0, 0, 1, I_NOP,  E_T2, 1};
    tv[9]  = '{0, 0, 1, I_NOP,  RUN, 1};
    tv[10] = '{0, 0, 1, I_NOP,  E_T0, 2};
    tv[11] = '{0, 0, 1, I_HALT, E_T1, 2};
    tv[12] = '{0, 0, 1, I_HALT, E_T2, 2};
    tv[13] = '{0, 0, 1, I_HALT, RUN, 2};
    tv[14] = '{0, 0, 1, I_HALT, 22'd0, 3};
    tv[15] = '{1, 0, 1, I_HALT, E_T0, 3};
    #12 rst_n = 1'b1;
    chk("reset_out", 32'(act), 0);
    chk("reset_cnt", 32'(bus.Instr_count), 0);
    tick();
    chk("idle_hold", 32'(act), 0);
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].st, tv[i].sp, tv[i].mr, tv[i].ir);
      tick();
      chk($sformatf("vec%0d", i), 32'(act), 32'(tv[i].ev));
      chk($sformatf("vec%0d_cnt", i), 32'(bus.Instr_count), 32'(tv[i].ec));
    end
    drive(0, 0, 0, I_ADD);
    tick();
    chk("wait_t1_0", 32'(act), 32'(E_T1));
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("wait_t1_%0d", i), 32'(act), 32'(E_T1));
    end
    bus.Mem_ready = 1'b1;
    tick();
    chk("wait_t2", 32'(act), 32'(E_T2));
    tick();
    chk("add_t3", 32'(act), 32'(E_T3A));
    bus.Stop = 1'b1;
    tick();
    chk("add_t4", 32'(act), 32'(E_T4 | alu_f(1)));
    tick();
    chk("add_t5", 32'(act), 32'(E_T5));
    tick();
    chk("stop_halted", 32'(act), 0);
    chk("stop_cnt", 32'(bus.Instr_count), 4);
    bus.Start = 1'b1;
    tick();
    chk("start_over_stop", 32'(act), 32'(E_T0));
    drive(0, 0, 1, I_ILL);
    repeat (3) tick();
    chk("ill_t3", 32'(act), 32'(RUN | ILL));
    tick();
    chk("ill_halted", 32'(act), 0);
    chk("ill_cnt", 32'(bus.Instr_count), 4);
    drive(1, 0, 1, I_SUB);
    tick();
    bus.Start = 1'b0;
    repeat (4) tick();
    chk("sub_t4", 32'(act), 32'(E_T4 | alu_f(2)));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(act), 0);
    chk("async_rst_cnt", 32'(bus.Instr_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(act), 0);
    m_step = -1;
    m_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      bus.Start = $urandom_range(0, 3) == 0;
      bus.Stop = $urandom_range(0, 3) == 0;
      bus.Mem_ready = $urandom_range(0, 3) != 0;
      if (m_step <= 0) begin
        logic [4:0] o;
        case ($urandom_range(0, 7))
          0, 1, 2: o = 5'($urandom_range(3, 6));
          3, 4:    o = 5'd26;
          5:       o = 5'd27;
          default: o = 5'($urandom_range(0, 31));
        endcase
        bus.IR = {o, 27'($urandom)};
      end
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_out", 32'(act), 32'(model_out(m_step, bus.IR[31:27])));
      chk("rnd_cnt", 32'(bus.Instr_count), 32'(m_cnt));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
